// File: rtl/gray_bin_conv_pipe.sv
// Registered Gray<->binary converter with a single-entry valid/ready output slot.
// Define GRAY_STEP_CHECK_EN to build the Gray step checker and its error counter.
module gray_bin_conv_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             mode_out,
  output logic             step_err,
  output logic [CNT_W-1:0] err_cnt
);

  // Handshake: a word moves when valid & ready are both high at a rising edge;
  // the slot refills in the same cycle it drains, so there is no bubble.
  logic             accept;
  logic [WIDTH-1:0] g2b;
  logic [WIDTH-1:0] b2g;
  logic [WIDTH-1:0] conv;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             mode_out_q, mode_out_d;
  logic             flag;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    g2b = '0;
    for (int i = 0; i < WIDTH; i++) begin
      g2b[i] = ^(din >> i);
    end
    b2g  = din ^ (din >> 1);
    conv = mode ? b2g : g2b;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    mode_out_d  = mode_out_q;
    if (accept) begin
      out_valid_d = 1'b1;
      dout_d      = conv;
      mode_out_d  = mode;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      mode_out_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      mode_out_q  <= mode_out_d;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  localparam int DW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] prev_g_q, prev_g_d;
  logic             prev_vld_q, prev_vld_d;
  logic             step_err_q, step_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] diff;
  logic [DW-1:0]    dist;

  always_comb begin
    diff = din ^ prev_g_q;
    dist = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dist = dist + DW'(diff[i]);
    end
    flag = !mode && prev_vld_q && (dist > DW'(1));
  end

  always_comb begin
    prev_g_d   = prev_g_q;
    prev_vld_d = prev_vld_q;
    step_err_d = step_err_q;
    err_cnt_d  = err_cnt_q;
    if (accept) begin
      step_err_d = flag;
      if (!mode) begin
        prev_g_d   = din;
        prev_vld_d = 1'b1;
      end
      // Counter sticks at all-ones until reset.
      if (flag && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_g_q   <= '0;
      prev_vld_q <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      prev_g_q   <= prev_g_d;
      prev_vld_q <= prev_vld_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;
`else
  assign flag     = 1'b0;
  assign step_err = flag;
  assign err_cnt  = '0;
`endif

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign mode_out  = mode_out_q;

endmodule

// File: doc/gray_bin_conv_pipe.md
# gray_bin_conv_pipe

Parametrised, registered Gray/binary code converter with valid/ready handshaking on both sides. Each accepted word is converted Gray→binary or binary→Gray according to a per-transaction mode bit and presented one cycle later. It sits on pointer and position-encoder paths, such as async FIFO pointer decode and rotary/absolute encoder inputs, where backpressure and stream framing are needed. An optional checker flags Gray inputs that change by more than one bit between consecutive words.

## Interface
Parameters:
- WIDTH, 8, code word width in bits (≥2)
- CNT_W, 8, width of the step-error counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word this cycle
- mode  input  1  0: din is Gray, convert to binary; 1: din is binary, convert to Gray
- din  input  WIDTH  input code word
- out_valid  output  1  dout valid
- out_ready  input  1  downstream accepts dout this cycle
- dout  output  WIDTH  converted word
- mode_out  output  1  mode of the word on dout
- step_err  output  1  word on dout failed the Gray step check
- err_cnt  output  CNT_W  saturating count of step errors

## Operation
- Gray→binary: dout[WIDTH-1] = din[WIDTH-1]; dout[i] = dout[i+1] ^ din[i] for i = WIDTH-2 down to 0. Equivalently, dout[i] is the XOR of din[WIDTH-1:i].
- Binary→Gray: dout = din ^ (din >> 1), with zero-fill at the MSB.
- Output register stage is a single entry:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept when in_valid & in_ready. On accept, load dout, mode_out and step_err, and set out_valid.
  - When out_valid & out_ready and no accept in the same cycle, clear out_valid.
  - Simultaneous drain and accept: the new word replaces the old one with no bubble. Full throughput is one word per cycle.
- While out_valid & !out_ready, dout, mode_out and step_err hold stable.
- While !in_valid, din and mode are don't-care.
- Step check (mode 0 words only):
  - prev_g (WIDTH bits) and prev_vld are updated on every accepted mode-0 word.
  - Hamming distance between din and prev_g of 0 or 1 is legal. A distance >1 sets step_err for that word.
  - The first mode-0 word after reset (prev_vld=0) is never flagged.
  - Mode-1 words are never flagged and do not touch prev_g or prev_vld.
- err_cnt increments on each accepted word with step_err=1. It saturates at 2^CNT_W−1 and is cleared only by rst.

## Timing
- Latency: a word accepted at edge N is valid on dout after edge N, with out_valid=1 in cycle N+1.
- Reset (async assert, outputs forced immediately):
  - out_valid=0, dout=0, mode_out=0, step_err=0, err_cnt=0, prev_g=0, prev_vld=0.
  - in_ready=1 follows combinationally.
- Reset mid-transfer drops the held word; no output is produced for it.
- Release is synchronous to clk by the surrounding reset logic. The first accept can occur on the first edge after deassertion.
- Step check, Hamming compare and conversion are all combinational ahead of the output register. There is no added latency.

## Configuration
- GRAY_STEP_CHECK_EN defined: the step checker, prev_g, prev_vld and err_cnt logic are implemented as described.
- GRAY_STEP_CHECK_EN undefined:
  - The checker logic is removed.
  - step_err is tied 0 and err_cnt is tied 0; the ports remain.
  - Conversion and handshake behaviour are unchanged.

## Test plan
- Gray→binary, WIDTH=8: mode=0, din=8'hC3, out_ready=1 → next cycle out_valid=1, dout=8'h82, mode_out=0, step_err=0.
- Binary→Gray: mode=1, din=8'h2D → dout=8'h3B. Then a back-to-back stream of 8'h00..8'hFF with out_ready=1 → 256 outputs on consecutive cycles, each dout = i ^ (i>>1).
- Backpressure: accept 8'h01 (mode 1), then hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and dout=8'h01 stable for 3 cycles. Raise out_ready → the next word enters with no bubble.
- Step check (macro defined): mode-0 words 8'h00, 8'h01, 8'h01, 8'h07.
  - step_err sequence is 0, 0, 0, 1; err_cnt=1.
  - An interleaved mode-1 word 8'hFF does not affect the check.
  - With the macro undefined, step_err=0 and err_cnt=0 throughout.
- Saturation: CNT_W=2, five flagged words → err_cnt reads 1, 2, 3, 3, 3.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0.
  - out_valid=0, dout=0 and err_cnt=0 immediately, before the next edge.
  - After release, the first mode-0 word 8'hFF is not flagged.
